// File: rtl/avalon_burst_memory_adapter_if.sv
// Avalon-MM bursting memory port bundle.
// The host drives commands and write beats; the adapter answers on waitrequest/read_valid.
interface avalon_burst_memory_adapter_if #(
   parameter int DATAWIDTH  = 32,
   parameter int ADDRWIDTH  = 8,
   parameter int BURSTWIDTH = 4
);
   logic                    read;
   logic                    write;
   logic [ADDRWIDTH-1:0]    address;
   logic [BURSTWIDTH-1:0]   burstcount;
   logic [DATAWIDTH/8-1:0]  byteenable;
   logic [DATAWIDTH-1:0]    data_in;
   logic                    waitrequest;
   logic                    read_valid;
   logic [DATAWIDTH-1:0]    data_out;

   modport master (
      output read, write, address, burstcount, byteenable, data_in,
      input  waitrequest, read_valid, data_out
   );

   modport slave (
      input  read, write, address, burstcount, byteenable, data_in,
      output waitrequest, read_valid, data_out
   );
endinterface

// File: rtl/avalon_burst_memory_adapter.sv
// Bursting Avalon-MM slave onto a single-port synchronous memory.
// Read data returns through a LATENCY-deep valid pipeline.
module avalon_burst_memory_adapter #(
   parameter int DATAWIDTH  = 32,
   parameter int DATADEPTH  = 256,
   parameter int ADDRWIDTH  = $clog2(DATADEPTH),
   parameter int BURSTWIDTH = 4,
   parameter int LATENCY    = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   avalon_burst_memory_adapter_if.slave av,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [ADDRWIDTH-1:0]   mem_address,
   output logic [DATAWIDTH/8-1:0] mem_byteenable,
   output logic [DATAWIDTH-1:0]   mem_wr_data,
   input  logic [DATAWIDTH-1:0]   mem_rd_data
);
   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

   state_t                state;
   logic [BURSTWIDTH-1:0] remaining;
   logic [BURSTWIDTH-1:0] beats;
   logic [ADDRWIDTH-1:0]  next_address;
   logic                  rd_beat;
   logic [LATENCY-1:0]    pipe_vld;
   logic [LATENCY-1:0]    pipe_oor;

   function automatic logic in_range(input logic [ADDRWIDTH-1:0] a);
      return 32'(a) < 32'(DATADEPTH);
   endfunction

   function automatic logic [ADDRWIDTH-1:0] inc_addr(
      input logic [ADDRWIDTH-1:0] a
   );
      return (32'(a) == 32'(DATADEPTH - 1)) ? '0 : a + ADDRWIDTH'(1);
   endfunction

   assign beats        = (av.burstcount == '0) ? BURSTWIDTH'(1)
                                               : av.burstcount;
   assign next_address = inc_addr(mem_address);
   assign av.waitrequest = (state == RD_BURST);
   assign av.read_valid  = pipe_vld[LATENCY-1];
   // Out-of-range read beats still occupy a return slot but yield zero.
   assign av.data_out = (pipe_vld[LATENCY-1] && !pipe_oor[LATENCY-1])
                        ? mem_rd_data : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         remaining      <= '0;
         rd_beat        <= 1'b0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_byteenable <= '0;
         mem_wr_data    <= '0;
         pipe_vld       <= '0;
         pipe_oor       <= '0;
      end else begin
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         rd_beat     <= 1'b0;
         pipe_vld[0] <= rd_beat;
         pipe_oor[0] <= rd_beat & ~mem_read;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_oor[i] <= pipe_oor[i-1];
         end
         unique case (state)
            IDLE: begin
               if (av.write) begin
                  mem_write      <= in_range(av.address);
                  mem_address    <= av.address;
                  mem_wr_data    <= av.data_in;
                  mem_byteenable <= av.byteenable;
                  if (beats > BURSTWIDTH'(1)) begin
                     state     <= WR_BURST;
                     remaining <= beats - BURSTWIDTH'(1);
                  end
               end else if (av.read) begin
                  mem_read    <= in_range(av.address);
                  rd_beat     <= 1'b1;
                  mem_address <= av.address;
                  remaining   <= beats;
                  state       <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (remaining == BURSTWIDTH'(1)) begin
                  state <= IDLE;
               end else begin
                  mem_read    <= in_range(next_address);
                  rd_beat     <= 1'b1;
                  mem_address <= next_address;
                  remaining   <= remaining - BURSTWIDTH'(1);
               end
            end
            WR_BURST: begin
               if (av.write) begin
                  mem_write      <= in_range(next_address);
                  mem_address    <= next_address;
                  mem_wr_data    <= av.data_in;
                  mem_byteenable <= av.byteenable;
                  remaining      <= remaining - BURSTWIDTH'(1);
                  if (remaining == BURSTWIDTH'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_avalon_burst_memory_adapter.sv
// Randomised scoreboard bench for avalon_burst_memory_adapter.
// DATADEPTH=200 exercises wrap and out-of-range handling with LATENCY=3.
module tb_avalon_burst_memory_adapter;
   localparam int DW    = 32;
   localparam int DEPTH = 200;
   localparam int AW    = 8;
   localparam int BW    = 4;
   localparam int LAT   = 3;

   typedef struct { logic [31:0] d; int cyc; } rexp_t;
   typedef struct { logic [7:0] a; int cyc; } aexp_t;
   typedef struct {
      logic [7:0] a; logic [31:0] d; logic [3:0] be; int cyc;
   } wexp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [3:0] mem_byteenable;
   logic [DW-1:0] mem_wr_data, mem_rd_data;

   avalon_burst_memory_adapter_if #(
      .DATAWIDTH(DW), .ADDRWIDTH(AW), .BURSTWIDTH(BW)
   ) av ();

   avalon_burst_memory_adapter #(
      .DATAWIDTH(DW), .DATADEPTH(DEPTH), .ADDRWIDTH(AW),
      .BURSTWIDTH(BW), .LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .av(av),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [256];
   logic [31:0] ram [256];
   logic [31:0] rpipe [LAT];
   logic ram_init = 1'b0;
   rexp_t rq[$];
   aexp_t aq[$];
   wexp_t wq[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural memory with LAT-cycle read latency.
   always @(posedge clk) begin
      if (reset && !ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= ref_mem[i];
         ram_init <= 1'b1;
      end else if (mem_write) begin
         for (int b = 0; b < 4; b++)
            if (mem_byteenable[b])
               ram[mem_address][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end
      rpipe[0] <= mem_read ? ram[mem_address] : 32'hBADC0DE5;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign mem_rd_data = rpipe[LAT-1];

   function automatic void chk(input string nm,
                               input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (av.read_valid) begin
         if (rq.size() == 0) chk("unexpected_read_valid", 1, 0);
         else begin
            rexp_t e;
            e = rq.pop_front();
            chk("read_data", av.data_out, e.d);
            chk("read_cycle", cyc, e.cyc);
         end
      end else begin
         chk("data_out_idle_zero", av.data_out, 0);
      end
      if (mem_write) begin
         if (wq.size() == 0) chk("unexpected_mem_write", 1, 0);
         else begin
            wexp_t w;
            w = wq.pop_front();
            chk("wr_addr", mem_address, w.a);
            chk("wr_data", mem_wr_data, w.d);
            chk("wr_be", mem_byteenable, w.be);
            chk("wr_cycle", cyc, w.cyc);
         end
      end
      if (mem_read) begin
         if (aq.size() == 0) chk("unexpected_mem_read", 1, 0);
         else begin
            aexp_t r;
            r = aq.pop_front();
            chk("rd_addr", mem_address, r.a);
            chk("rd_cycle", cyc, r.cyc);
         end
         chk("rd_wr_exclusive", mem_write, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] beat_addr(input logic [7:0] a0,
                                            input int k);
      if (int'(a0) >= DEPTH) return a0;
      return 8'((int'(a0) + k) % DEPTH);
   endfunction

   task automatic do_write(input logic [7:0] a0, input logic [3:0] bc,
                           input logic [31:0] d0, input logic [3:0] be0,
                           input bit rnd, input int stall_at,
                           input int stall_len, input bit both);
      int n;
      int s;
      logic [7:0] a;
      logic [31:0] d;
      logic [3:0] be;
      n = (bc == 0) ? 1 : int'(bc);
      for (int k = 0; k < n; k++) begin
         if (k > 0 && ((rnd && $urandom_range(0, 3) == 0) ||
                       (!rnd && k == stall_at))) begin
            s = rnd ? int'($urandom_range(1, 3)) : stall_len;
            av.write = 1'b0;
            av.read  = 1'($urandom);
            repeat (s) tick();
         end
         a  = beat_addr(a0, k);
         d  = rnd ? $urandom : d0 + 32'(k);
         be = (rnd && k > 0) ? 4'($urandom) : be0;
         av.write      = 1'b1;
         av.read       = (k == 0) ? both : 1'($urandom);
         av.address    = (k == 0) ? a0 : 8'($urandom);
         av.burstcount = (k == 0) ? bc : 4'($urandom);
         av.data_in    = d;
         av.byteenable = be;
         chk("wr_waitrequest_low", av.waitrequest, 0);
         if (int'(a) < DEPTH) begin
            wq.push_back('{a: a, d: d, be: be, cyc: cyc + 1});
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
         end
         tick();
      end
      av.write = 1'b0;
      av.read  = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] a0, input logic [3:0] bc);
      int n;
      int t;
      int cnt;
      logic [7:0] a;
      n = (bc == 0) ? 1 : int'(bc);
      t = cyc;
      av.read       = 1'b1;
      av.write      = 1'b0;
      av.address    = a0;
      av.burstcount = bc;
      for (int k = 0; k < n; k++) begin
         a = beat_addr(a0, k);
         if (int'(a) < DEPTH) begin
            aq.push_back('{a: a, cyc: t + 1 + k});
            rq.push_back('{d: ref_mem[a], cyc: t + 1 + k + LAT});
         end else begin
            rq.push_back('{d: 32'h0, cyc: t + 1 + k + LAT});
         end
      end
      tick();
      av.read       = 1'b0;
      av.address    = 8'($urandom);
      av.burstcount = 4'($urandom);
      cnt = 0;
      while (av.waitrequest && cnt < 64) begin
         cnt++;
         tick();
      end
      chk("rd_waitrequest_cycles", cnt, n);
   endtask

   initial begin
      int t;
      int r;
      logic [7:0] a;
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      av.read = 1'b0;
      av.write = 1'b0;
      av.address = '0;
      av.burstcount = '0;
      av.byteenable = '0;
      av.data_in = '0;
      repeat (3) tick();
      chk("rst_waitrequest", av.waitrequest, 0);
      chk("rst_read_valid", av.read_valid, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_address", mem_address, 0);
      chk("rst_mem_wr_data", mem_wr_data, 0);
      chk("rst_mem_byteenable", mem_byteenable, 0);
      reset = 1'b0;
      tick();

      do_write(8'h10, 4'd1, 32'hDEADBEEF, 4'hF, 0, -1, 0, 0);
      do_read(8'h10, 4'd1);
      do_write(8'd198, 4'd4, 32'd1, 4'hF, 0, 2, 2, 0);
      do_read(8'd198, 4'd4);
      do_write(8'h10, 4'd1, 32'h00001234, 4'h3, 0, -1, 0, 1);
      do_read(8'h10, 4'd1);
      do_read(8'd199, 4'd2);
      do_write(8'd250, 4'd1, 32'hCAFEF00D, 4'hF, 0, -1, 0, 0);
      do_read(8'd250, 4'd1);
      do_read(8'd5, 4'd0);
      do_write(8'd7, 4'd0, 32'h55AA55AA, 4'hF, 0, -1, 0, 0);
      do_read(8'd7, 4'd1);
      do_read(8'd190, 4'd8);

      // Reset after the second beat of a 4-beat read has been issued.
      t = cyc;
      av.read = 1'b1;
      av.address = 8'd50;
      av.burstcount = 4'd4;
      aq.push_back('{a: 8'd50, cyc: t + 1});
      aq.push_back('{a: 8'd51, cyc: t + 2});
      tick();
      av.read = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_rst_waitrequest", av.waitrequest, 0);
      chk("post_rst_mem_read", mem_read, 0);
      chk("post_rst_read_valid", av.read_valid, 0);
      do_read(8'd60, 4'd2);

      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            a = 8'($urandom_range(DEPTH, 255));
            if ($urandom_range(0, 1) == 1)
               do_write(a, 4'd1, $urandom, 4'hF, 0, -1, 0, 0);
            else
               do_read(a, 4'd1);
         end else begin
            a = 8'($urandom_range(0, DEPTH - 1));
            if (r < 5)
               do_write(a, 4'($urandom_range(0, 8)), 32'h0,
                        4'($urandom), 1, -1, 0, 1'($urandom));
            else
               do_read(a, 4'($urandom_range(0, 8)));
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (LAT + 10) tick();
      chk("read_queue_drained", rq.size(), 0);
      chk("addr_queue_drained", aq.size(), 0);
      chk("write_queue_drained", wq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/avalon_burst_memory_adapter.md
Name: avalon_burst_memory_adapter

Overview:
Parametrised Avalon-MM slave adapter that bridges a bursting Avalon memory port onto a native single-port synchronous memory interface inside a peripheral. It generalises the fixed single-beat memory adapter with configurable width, depth, read latency, byte enables, burst transfers, waitrequest back-pressure and out-of-range protection. It sits between the peripheral top-level Avalon memory port and the peripheral core's memory.

Parameters:
DATAWIDTH, 32, data bus width in bits; multiple of 8
DATADEPTH, 256, memory words; need not be a power of two
ADDRWIDTH, $clog2(DATADEPTH), word address width
BURSTWIDTH, 4, burstcount width; max burst 2^(BURSTWIDTH-1) beats
LATENCY, 1, memory read latency in cycles (mem_read to mem_rd_data valid), >=1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
read  input  1  Avalon read command
write  input  1  Avalon write command / write data beat
address  input  ADDRWIDTH  Avalon word address (first beat only)
burstcount  input  BURSTWIDTH  beats in burst (sampled with command)
byteenable  input  DATAWIDTH/8  per-byte write enables
data_in  input  DATAWIDTH  Avalon write data
waitrequest  output  1  command/beat not accepted this cycle
read_valid  output  1  data_out valid
data_out  output  DATAWIDTH  Avalon read data
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_address  output  ADDRWIDTH  memory word address
mem_byteenable  output  DATAWIDTH/8  memory byte enables
mem_wr_data  output  DATAWIDTH  memory write data
mem_rd_data  input  DATAWIDTH  memory read data, valid LATENCY cycles after mem_read

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state IDLE; mem_read/mem_write/read_valid 0; data_out, mem_address, mem_wr_data, mem_byteenable 0; latency pipeline flushed. Reset mid-burst abandons the burst; in-flight reads produce no read_valid.
- States: IDLE, RD_BURST, WR_BURST. waitrequest = 1 only in RD_BURST, 0 otherwise (combinational from state).
- IDLE, write=1 (write wins if read also 1): beat 0 accepted at cycle T. Cycle T+1: mem_write=1, mem_address=address, data/byteenable registered. If burstcount>1, go to WR_BURST with remaining = burstcount-1.
- WR_BURST: each cycle with write=1 is one beat, issued to memory next cycle at incremented address. write=0 stalls without timeout. read is ignored. IDLE after last beat.
- IDLE, read=1, write=0: accepted at T; go to RD_BURST for N=burstcount cycles (T+1..T+N). mem_read=1 each cycle at address, address+1, …. IDLE at T+N+1; next command accepted then.
- Read return: read_valid=1 with data_out=beat k at T+1+k+LATENCY. Beats are in order and back-to-back. data_out=0 whenever read_valid=0.
- burstcount=0 is treated as 1.
- Address increments modulo DATADEPTH: after DATADEPTH-1, wraps to 0.
- Out-of-range beat (address >= DATADEPTH, only possible if DATADEPTH is not a power of two): mem_read/mem_write are suppressed. A read still returns read_valid with data_out=0 at the normal slot. A write is silently dropped.
- mem_write and mem_read are never high in the same cycle. Strobes are single-cycle per beat.

Test Plan:
- Single write addr 0x10, data 0xDEADBEEF, byteenable 0xF, then single read addr 0x10 -> mem_write at T+1. read_valid at read accept+2 (LATENCY=1) with data_out 0xDEADBEEF.
- Write burst addr 0xFE, burstcount 4, data 1..4, write deasserted for 2 cycles after beat 1 -> mem_writes to 0xFE,0xFF,0x00,0x01 with data 1..4. waitrequest stays 0. Stall is honoured.
- Read burst 4 from 0xFE, LATENCY=3 -> waitrequest high 4 cycles. read_valid contiguous from T+4 to T+7 with data 1,2,3,4.
- Read and write asserted together in IDLE, byteenable 0x3 over existing 0xDEADBEEF with data 0x00001234 -> only write performed; subsequent read returns 0xDEAD1234.
- DATADEPTH=200, read addr 199 burst 2, then write to addr 250 -> beat 1 wraps to 0. Write to 250 produces no mem_write. A read of 250 returns read_valid with data_out 0.
- Reset asserted mid read burst (after beat 1 issued) -> next cycle state IDLE, waitrequest 0, no further read_valid or mem_read. New command accepted immediately.
